// File: rtl/echo_delay_if.sv
// Purpose: sample/control bundle for echo_delay.
// master drives: en, x_valid, x, delay_len, fb_gain, mix_gain, bypass
// slave drives : y, y_valid, busy, overrun
interface echo_delay_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned GAIN_WIDTH = 8
);
  logic                         en;
  logic                         x_valid;
  logic signed [DATA_WIDTH-1:0] x;
  logic [ADDR_WIDTH-1:0]        delay_len;
  logic [GAIN_WIDTH-1:0]        fb_gain;
  logic [GAIN_WIDTH-1:0]        mix_gain;
  logic                         bypass;
  logic signed [DATA_WIDTH-1:0] y;
  logic                         y_valid;
  logic                         busy;
  logic                         overrun;

  modport master (
    output en, x_valid, x, delay_len, fb_gain, mix_gain, bypass,
    input  y, y_valid, busy, overrun
  );

  modport slave (
    input  en, x_valid, x, delay_len, fb_gain, mix_gain, bypass,
    output y, y_valid, busy, overrun
  );
endinterface

// File: rtl/echo_delay.sv
// Purpose: single-tap feedback echo. Each accepted sample reads the delay line
// delay_len samples back, writes x + fb*d into it and outputs x + mix*d
// (or x alone in bypass), saturated to DATA_WIDTH.
// Ports: clk, rst_n (async active-low), bus (echo_delay_if.slave).
module echo_delay #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE       = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned GAIN_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  echo_delay_if.slave bus
);
  localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                       r_state;
  logic [ADDR_WIDTH-1:0]        r_clr_cnt;
  logic [ADDR_WIDTH-1:0]        r_wr_ptr;
  logic [ADDR_WIDTH-1:0]        r_dl;
  logic [GAIN_WIDTH-1:0]        r_fb;
  logic [GAIN_WIDTH-1:0]        r_mix;
  logic                         r_byp;
  logic signed [DATA_WIDTH-1:0] r_x;
  logic signed [DATA_WIDTH-1:0] r_d;
  logic signed [DATA_WIDTH-1:0] r_w;
  logic signed [DATA_WIDTH-1:0] r_y_next;
  logic signed [DATA_WIDTH-1:0] r_y;
  logic                         r_y_pend;
  logic                         r_y_valid;
  logic                         r_busy;
  logic                         r_overrun;
  logic signed [DATA_WIDTH-1:0] r_mem [SIZE];

  logic                         w_accept;
  logic                         w_offer_busy;
  logic [ADDR_WIDTH-1:0]        w_rd_addr;
  logic                         w_we;
  logic [ADDR_WIDTH-1:0]        w_waddr;
  logic signed [DATA_WIDTH-1:0] w_wdata;
  logic signed [PW-1:0]         w_d_ext;
  logic signed [PW-1:0]         w_x_ext;
  logic signed [PW-1:0]         w_fb_ext;
  logic signed [PW-1:0]         w_mix_ext;
  logic signed [PW-1:0]         w_fb_sh;
  logic signed [PW-1:0]         w_mix_sh;
  logic signed [PW-1:0]         w_w_sum;
  logic signed [PW-1:0]         w_y_sum;

  // Clamp a wide signed value into the DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] s);
    if (s > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    else                  sat = s[DATA_WIDTH-1:0];
  endfunction

  assign w_accept     = bus.en & bus.x_valid & (r_state == S_IDLE);
  assign w_offer_busy = bus.en & bus.x_valid & (r_state != S_IDLE);

  // delay_len of 0 wraps to the slot about to be overwritten: a SIZE-sample delay.
  assign w_rd_addr = r_wr_ptr - r_dl;

  assign w_we    = (r_state == S_CLEAR) | (r_state == S_WRITE);
  assign w_waddr = (r_state == S_CLEAR) ? r_clr_cnt : r_wr_ptr;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : r_w;

  // Signed d times unsigned Q0.GAIN gain, floor-shifted back to sample scale.
  // Sums are carried at product width; both terms fit DATA_WIDTH bits, so the
  // result equals a DATA_WIDTH+1 sum.
  assign w_d_ext   = {{(PW-DATA_WIDTH){r_d[DATA_WIDTH-1]}}, r_d};
  assign w_x_ext   = {{(PW-DATA_WIDTH){r_x[DATA_WIDTH-1]}}, r_x};
  assign w_fb_ext  = {{(PW-GAIN_WIDTH){1'b0}}, r_fb};
  assign w_mix_ext = {{(PW-GAIN_WIDTH){1'b0}}, r_mix};
  assign w_fb_sh   = (w_d_ext * w_fb_ext) >>> GAIN_WIDTH;
  assign w_mix_sh  = (w_d_ext * w_mix_ext) >>> GAIN_WIDTH;
  assign w_w_sum   = w_x_ext + w_fb_sh;
  assign w_y_sum   = w_x_ext + w_mix_sh;

  // Delay line: clear/write port plus synchronous read issued in READ.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (r_state == S_READ) r_d <= r_mem[w_rd_addr];
  end

  // Control FSM with registered outputs; y/y_valid update one edge after WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_wr_ptr  <= '0;
      r_dl      <= '0;
      r_fb      <= '0;
      r_mix     <= '0;
      r_byp     <= 1'b0;
      r_x       <= '0;
      r_w       <= '0;
      r_y_next  <= '0;
      r_y       <= '0;
      r_y_pend  <= 1'b0;
      r_y_valid <= 1'b0;
      r_busy    <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_y_valid <= r_y_pend;
      r_y_pend  <= 1'b0;
      if (r_y_pend) r_y <= r_y_next;
      if (w_offer_busy) r_overrun <= 1'b1;

      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          if (r_clr_cnt == ADDR_WIDTH'(SIZE - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_x     <= bus.x;
            r_dl    <= bus.delay_len;
            r_fb    <= bus.fb_gain;
            r_mix   <= bus.mix_gain;
            r_byp   <= bus.bypass;
            r_state <= S_READ;
            r_busy  <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_w      <= sat(w_w_sum);
          r_y_next <= r_byp ? r_x : sat(w_y_sum);
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
          r_y_pend <= 1'b1;
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_cnt <= '0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.y       = r_y;
  assign bus.y_valid = r_y_valid;
  assign bus.busy    = r_busy;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_echo_delay.sv
// Purpose: self-checking bench for echo_delay (DATA_WIDTH=32, SIZE=8, GAIN_WIDTH=8).
// Reference model keeps the full history of written tap values and looks back
// delay samples in it; a never-written slot reads as zero.
module tb_echo_delay;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int GW = 8;
  localparam int SZ = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  longint hist[$];

  echo_delay_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GAIN_WIDTH(GW)) bus();

  echo_delay #(.DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW), .GAIN_WIDTH(GW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
    $fatal(1, "watchdog");
  end

  function automatic longint sat_ref(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // floor(d * g / 2**GW) using plain division
  function automatic longint scaled(input longint d, input int g);
    longint p;
    longint q;
    p = d * longint'(g);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q;
  endfunction

  function automatic longint model(input longint x, input int dl, input int fb,
                                   input int mix, input bit byp);
    int     n;
    int     dly;
    longint d;
    longint w;
    n   = hist.size();
    dly = (dl == 0) ? SZ : dl;
    d   = (n >= dly) ? hist[n - dly] : 0;
    w   = sat_ref(x + scaled(d, fb));
    hist.push_back(w);
    return byp ? x : sat_ref(x + scaled(d, mix));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.x_valid = 1'b0;
    repeat (2) @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
  endtask

  // One sample through the pipe; controls are scrambled right after acceptance.
  task automatic send(input logic [31:0] xv, input int dl, input int fb, input int mix,
                      input bit byp, input bit hold_xv, input string tag);
    longint      xs;
    logic [31:0] exp;
    xs  = longint'($signed(xv));
    exp = 32'(model(xs, dl, fb, mix, byp));
    wait_idle();
    bus.en = 1'b1; bus.x_valid = 1'b1; bus.x = xv;
    bus.delay_len = 3'(dl); bus.fb_gain = 8'(fb); bus.mix_gain = 8'(mix); bus.bypass = byp;
    @(negedge clk);
    bus.en = 1'b0; bus.x_valid = hold_xv; bus.x = $urandom;
    bus.delay_len = 3'($urandom); bus.fb_gain = 8'($urandom); bus.mix_gain = 8'($urandom);
    bus.bypass = 1'($urandom);
    repeat (3) @(negedge clk);
    bus.x_valid = 1'b0;
    check({tag, "_vld_early"}, 32'(bus.y_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'(bus.y_valid), 32'd1);
    check({tag, "_y"}, bus.y, exp);
    @(negedge clk);
    check({tag, "_vld_drop"}, 32'(bus.y_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] exq[$];
    int          pulses;
    logic [31:0] xc;
    int          dlc;

    rst_n = 1'b0;
    bus.en = 1'b0; bus.x_valid = 1'b0; bus.x = '0; bus.delay_len = '0;
    bus.fb_gain = '0; bus.mix_gain = '0; bus.bypass = 1'b0;

    // Reset state and CLEAR duration
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_y", bus.y, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("clr_busy", 32'(bus.busy), 32'd1);
      check("clr_vld", 32'(bus.y_valid), 32'd0);
      check("clr_ovr", 32'(bus.overrun), 32'd0);
      @(negedge clk);
    end
    check("clr_done_busy", 32'(bus.busy), 32'd0);
    check("clr_done_y", bus.y, 32'd0);

    // Single echo at delay 3, no feedback
    send(32'd1000, 3, 0, 128, 1'b0, 1'b0, "d3_0");
    for (int i = 0; i < 7; i++) send(32'd0, 3, 0, 128, 1'b0, 1'b0, "d3_z");

    // Decaying feedback echo at delay 2
    do_reset();
    send(32'd1024, 2, 128, 128, 1'b0, 1'b0, "fb_0");
    for (int i = 0; i < 6; i++) send(32'd0, 2, 128, 128, 1'b0, 1'b0, "fb_z");

    // delay_len 0 means a full SIZE-sample delay
    do_reset();
    send(32'd1024, 0, 0, 128, 1'b0, 1'b0, "d0_0");
    for (int i = 0; i < 8; i++) send(32'd0, 0, 0, 128, 1'b0, 1'b0, "d0_z");

    // Positive and negative saturation
    do_reset();
    send(32'h7FFFFFF0, 1, 255, 255, 1'b0, 1'b0, "satp_0");
    send(32'h7FFFFFF0, 1, 255, 255, 1'b0, 1'b0, "satp_1");
    check("satp_const", bus.y, 32'h7FFFFFFF);
    do_reset();
    send(32'h80000010, 1, 255, 255, 1'b0, 1'b0, "satn_0");
    send(32'h80000010, 1, 255, 255, 1'b0, 1'b0, "satn_1");
    check("satn_const", bus.y, 32'h80000000);

    // x_valid offered while busy with en low: no overrun
    do_reset();
    send(32'd77, 1, 200, 100, 1'b0, 1'b1, "enlow");
    check("enlow_ovr", 32'(bus.overrun), 32'd0);

    // Randomized samples including bypass
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 3) == 0), 1'($urandom), "rnd");
    end
    check("rnd_ovr", 32'(bus.overrun), 32'd0);

    // x_valid held high: one acceptance per 4 cycles, sticky overrun
    wait_idle();
    xc  = 32'($urandom_range(0, 100000));
    dlc = $urandom_range(0, 7);
    for (int i = 0; i < 4; i++) exq.push_back(32'(model(longint'($signed(xc)), dlc, 64, 192, 1'b0)));
    bus.en = 1'b1; bus.x_valid = 1'b1; bus.x = xc;
    bus.delay_len = 3'(dlc); bus.fb_gain = 8'd64; bus.mix_gain = 8'd192; bus.bypass = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) check("hold_ovr_first", 32'(bus.overrun), 32'd0);
      if (k == 2) check("hold_ovr_set", 32'(bus.overrun), 32'd1);
      if (k == 16) begin bus.en = 1'b0; bus.x_valid = 1'b0; end
      if (bus.y_valid === 1'b1) begin
        pulses++;
        if (exq.size() > 0) check("hold_y", bus.y, exq.pop_front());
      end
    end
    check("hold_pulses", 32'(pulses), 32'd4);
    send(32'd5, 1, 0, 0, 1'b1, 1'b0, "hold_after");
    check("hold_ovr_sticky", 32'(bus.overrun), 32'd1);

    // Reset during WRITE discards the in-flight impulse
    send(32'd1234, 2, 0, 0, 1'b1, 1'b0, "pre_rst");
    wait_idle();
    bus.en = 1'b1; bus.x_valid = 1'b1; bus.x = 32'd1000;
    bus.delay_len = 3'd1; bus.fb_gain = 8'd255; bus.mix_gain = 8'd255; bus.bypass = 1'b0;
    @(negedge clk);
    bus.en = 1'b0; bus.x_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("wr_rst_y", bus.y, 32'd0);
    check("wr_rst_ovr", 32'(bus.overrun), 32'd0);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 2) begin hist.delete(); rst_n = 1'b1; end
      if (bus.y_valid !== 1'b0) pulses++;
      if (k == 3) check("wr_rst_busy", 32'(bus.busy), 32'd1);
    end
    check("wr_rst_no_pulse", 32'(pulses), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(32'd0, 1, 255, 255, 1'b0, 1'b0, "post_rst");
      check("post_rst_zero", bus.y, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
